// File: rtl/uart_tx_arbiter.sv
// Arbitrates channels A and B onto one uart_tx: B has priority, and A is forced after MAX_BURST back-to-back B grants.
// Define UART_TX_ARB_STATS_EN to add per-channel pop counters (o_a_count/o_b_count, cleared by i_stats_clr).
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_a_dat,
  input  logic       i_a_valid,
  output logic       o_a_pop,
  input  logic [7:0] i_b_dat,
  input  logic       i_b_valid,
  output logic       o_b_pop,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_start,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_grant
`ifdef UART_TX_ARB_STATS_EN
  ,
  input  logic        i_stats_clr,
  output logic [15:0] o_a_count,
  output logic [15:0] o_b_count
`endif
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state;
  logic [3:0] burst_cnt;
  logic [3:0] tmo_cnt;
  logic       can_grant;
  logic       grant_b;
  logic [6:0] sel_lo;
  logic       unused_msb;

  // Bit 7 of each source is replaced by the channel tag on the wire.
  assign unused_msb = i_a_dat[7] ^ i_b_dat[7];
  assign can_grant  = (state == IDLE) && i_tx_ready && (i_a_valid || i_b_valid);
  assign grant_b    = i_b_valid && !(i_a_valid && (burst_cnt >= 4'(MAX_BURST)));
  assign sel_lo     = grant_b ? i_b_dat[6:0] : i_a_dat[6:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_tx_dat   <= 8'h00;
      o_tx_start <= 1'b0;
      o_a_pop    <= 1'b0;
      o_b_pop    <= 1'b0;
      o_busy     <= 1'b0;
      o_grant    <= 1'b0;
      burst_cnt  <= 4'd0;
      tmo_cnt    <= 4'd0;
    end else begin
      o_tx_start <= 1'b0;
      o_a_pop    <= 1'b0;
      o_b_pop    <= 1'b0;
      case (state)
        IDLE: if (can_grant) begin
          state      <= START;
          o_tx_dat   <= {grant_b, sel_lo};
          o_grant    <= grant_b;
          o_a_pop    <= !grant_b;
          o_b_pop    <= grant_b;
          o_tx_start <= 1'b1;
          o_busy     <= 1'b1;
          // Only B grants that bypass a waiting A count toward the burst.
          if (grant_b && i_a_valid)
            burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
          else
            burst_cnt <= 4'd0;
        end
        START: begin
          state   <= WAIT_BUSY;
          tmo_cnt <= 4'd0;
        end
        WAIT_BUSY: begin
          if (!i_tx_ready) begin
            state <= WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
            // uart_tx never showed busy; assume the byte went out.
            if ({1'b0, tmo_cnt} + 5'd1 == 5'(BUSY_TIMEOUT)) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        WAIT_DONE: if (i_tx_ready) begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_a_count <= 16'd0;
      o_b_count <= 16'd0;
    end else if (i_stats_clr) begin
      o_a_count <= 16'd0;
      o_b_count <= 16'd0;
    end else if (can_grant) begin
      if (grant_b) o_b_count <= o_b_count + 16'd1;
      else         o_a_count <= o_a_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: event-level reference model compared every cycle, plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int MAX_BURST    = 4;
  localparam int BUSY_TIMEOUT = 4;

  logic       i_clk = 1'b0, i_reset_n = 1'b1;
  logic [7:0] i_a_dat = 8'h00, i_b_dat = 8'h00;
  logic       i_a_valid = 1'b0, i_b_valid = 1'b0, i_tx_ready = 1'b1;
  logic       o_a_pop, o_b_pop, o_tx_start, o_busy, o_grant;
  logic [7:0] o_tx_dat;
`ifdef UART_TX_ARB_STATS_EN
  logic        i_stats_clr = 1'b0;
  logic [15:0] o_a_count, o_b_count;
`endif

  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.MAX_BURST(MAX_BURST), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_dat(i_a_dat), .i_a_valid(i_a_valid), .o_a_pop(o_a_pop),
    .i_b_dat(i_b_dat), .i_b_valid(i_b_valid), .o_b_pop(o_b_pop),
    .o_tx_dat(o_tx_dat), .o_tx_start(o_tx_start), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_grant(o_grant)
`ifdef UART_TX_ARB_STATS_EN
    , .i_stats_clr(i_stats_clr), .o_a_count(o_a_count), .o_b_count(o_b_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // Reference model: tracks one transfer as a window of events after a grant.
  bit        m_busy, m_start_cyc, m_low_seen, m_grant, m_apop, m_bpop, m_start;
  int        m_hi, m_burst;
  logic [7:0] m_dat;
  int        m_acnt, m_bcnt;

  task automatic model_reset();
    m_busy = 0; m_start_cyc = 0; m_low_seen = 0; m_grant = 0;
    m_apop = 0; m_bpop = 0; m_start = 0; m_hi = 0; m_burst = 0;
    m_dat = 8'h00; m_acnt = 0; m_bcnt = 0;
  endtask

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) model_reset();
    else begin
      bit g;
      m_apop = 0; m_bpop = 0; m_start = 0;
      if (!m_busy) begin
        if (i_tx_ready && (i_a_valid || i_b_valid)) begin
          g = i_b_valid && !(i_a_valid && m_burst >= MAX_BURST);
          m_dat   = g ? {1'b1, i_b_dat[6:0]} : {1'b0, i_a_dat[6:0]};
          m_grant = g; m_apop = !g; m_bpop = g; m_start = 1;
          m_busy = 1; m_start_cyc = 1; m_hi = 0; m_low_seen = 0;
          m_burst = (g && i_a_valid) ? ((m_burst < 15) ? m_burst + 1 : 15) : 0;
          if (g) m_bcnt = (m_bcnt + 1) % 65536; else m_acnt = (m_acnt + 1) % 65536;
        end
      end else if (m_start_cyc) m_start_cyc = 0;
      else if (m_low_seen) begin
        if (i_tx_ready) m_busy = 0;
      end else if (!i_tx_ready) m_low_seen = 1;
      else begin
        m_hi++;
        if (m_hi == BUSY_TIMEOUT) m_busy = 0;
      end
`ifdef UART_TX_ARB_STATS_EN
      if (i_stats_clr) begin m_acnt = 0; m_bcnt = 0; end
`endif
    end
  end

  typedef struct { int c; logic g; logic [7:0] d; } rec_t;
  rec_t log_q[$];

  always @(negedge i_clk) begin
    cyc++;
    chk("outputs_vs_model",
        {19'd0, o_tx_start, o_a_pop, o_b_pop, o_busy, o_grant, o_tx_dat},
        {19'd0, m_start, m_apop, m_bpop, m_busy, m_grant, m_dat});
`ifdef UART_TX_ARB_STATS_EN
    chk("counts_vs_model", {o_a_count, o_b_count}, {m_acnt[15:0], m_bcnt[15:0]});
`endif
    if (o_tx_start) log_q.push_back('{cyc, o_grant, o_tx_dat});
  end

  // Simple uart_tx stand-in: drops ready after each start for a while.
  bit uart_auto = 0, uart_rnd = 0;
  int uart_len = 3, ucnt = 0;
  initial forever begin
    @(posedge i_clk); #1;
    if (uart_auto) begin
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) i_tx_ready = 1;
      end else if (o_tx_start) begin
        if (uart_rnd && $urandom_range(3) == 0) i_tx_ready = 1;
        else begin
          ucnt = uart_rnd ? int'($urandom_range(8, 1)) : uart_len;
          i_tx_ready = 0;
        end
      end else if (uart_rnd) i_tx_ready = ($urandom_range(5) != 0);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 100) begin tick(); k++; end
    chk("wait_idle_bound", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    #1 i_reset_n = 0;
    #1;
    chk("reset_outputs", {19'd0, o_tx_start, o_a_pop, o_b_pop, o_busy, o_grant, o_tx_dat}, 32'd0);
    repeat (2) tick();
    i_reset_n = 1;
    tick();

    // Single A byte, uart busy for 10 cycles.
    i_a_dat = 8'hC1; i_a_valid = 1;
    tick();
    i_a_valid = 0;
    chk("single_a_pop", {31'd0, o_a_pop}, 32'd1);
    chk("single_a_start", {31'd0, o_tx_start}, 32'd1);
    chk("single_a_dat", {24'd0, o_tx_dat}, 32'h41);
    chk("single_a_grant", {31'd0, o_grant}, 32'd0);
    i_tx_ready = 0;
    repeat (10) tick();
    chk("busy_while_frame", {31'd0, o_busy}, 32'd1);
    i_tx_ready = 1;
    tick();
    chk("busy_falls_after_ready", {31'd0, o_busy}, 32'd0);

    // Contention with anti-starvation.
    log_q.delete();
    uart_len = 3; uart_auto = 1;
    i_a_dat = 8'hBA; i_b_dat = 8'h05; i_a_valid = 1; i_b_valid = 1;
    for (int k = 0; k < 300 && log_q.size() < 10; k++) tick();
    i_a_valid = 0; i_b_valid = 0;
    chk("contention_count", {31'd0, log_q.size() >= 10}, 32'd1);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      chk($sformatf("contention_grant%0d", i), {31'd0, log_q[i].g}, exp_g[i]);
      chk($sformatf("contention_dat%0d", i), {24'd0, log_q[i].d}, exp_g[i] ? 32'h85 : 32'h3A);
    end
    wait_idle();
    uart_auto = 0;
    while (ucnt > 0) tick();
    i_tx_ready = 1;
    tick();

    // Timeout: ready never drops, B streams.
    log_q.delete();
    i_b_dat = 8'h11; i_b_valid = 1;
    repeat (20) tick();
    i_b_valid = 0;
    wait_idle();
    chk("timeout_starts", {31'd0, log_q.size() >= 3}, 32'd1);
    for (int i = 0; i + 1 < log_q.size() && i < 2; i++)
      chk($sformatf("timeout_spacing%0d", i), log_q[i + 1].c - log_q[i].c, 32'd6);

    // Ready low in IDLE.
    i_tx_ready = 0; i_a_dat = 8'h22; i_a_valid = 1;
    bad = 0;
    repeat (20) begin
      tick();
      if (o_a_pop || o_b_pop || o_tx_start) bad++;
    end
    chk("no_pop_while_not_ready", bad, 32'd0);
    i_tx_ready = 1;
    tick();
    i_a_valid = 0;
    chk("late_grant_pop", {31'd0, o_a_pop}, 32'd1);
    chk("late_grant_dat", {24'd0, o_tx_dat}, 32'h22);
    wait_idle();

    // Reset while in WAIT_DONE.
    i_a_dat = 8'h55; i_a_valid = 1;
    tick();
    i_a_valid = 0; i_tx_ready = 0;
    tick(); tick();
    chk("in_wait_done_busy", {31'd0, o_busy}, 32'd1);
    #2 i_reset_n = 0;
    #1;
    chk("async_reset_outputs", {19'd0, o_tx_start, o_a_pop, o_b_pop, o_busy, o_grant, o_tx_dat}, 32'd0);
    tick();
    i_reset_n = 1; i_tx_ready = 1; i_a_dat = 8'h7F; i_a_valid = 1;
    tick();
    i_a_valid = 0;
    chk("post_reset_pop", {31'd0, o_a_pop}, 32'd1);
    chk("post_reset_dat", {24'd0, o_tx_dat}, 32'h7F);
    wait_idle();

`ifdef UART_TX_ARB_STATS_EN
    i_stats_clr = 1; tick(); i_stats_clr = 0;
    chk("stats_clr0", {o_a_count, o_b_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin i_a_valid = 1; tick(); i_a_valid = 0; wait_idle(); end
    for (int i = 0; i < 2; i++) begin i_b_valid = 1; tick(); i_b_valid = 0; wait_idle(); end
    chk("stats_a3", {16'd0, o_a_count}, 32'd3);
    chk("stats_b2", {16'd0, o_b_count}, 32'd2);
    i_stats_clr = 1; tick(); i_stats_clr = 0;
    chk("stats_clr1", {o_a_count, o_b_count}, 32'd0);
`endif

    // Randomized traffic with a randomly behaving uart_tx.
    uart_auto = 1; uart_rnd = 1;
    repeat (3000) begin
      tick();
      i_a_valid = $urandom_range(1) != 0;
      i_b_valid = $urandom_range(2) != 0;
      i_a_dat   = 8'($urandom);
      i_b_dat   = 8'($urandom);
`ifdef UART_TX_ARB_STATS_EN
      i_stats_clr = ($urandom_range(99) == 0);
`endif
    end
    i_a_valid = 0; i_b_valid = 0;
`ifdef UART_TX_ARB_STATS_EN
    i_stats_clr = 0;
`endif
    uart_rnd = 0; uart_auto = 0; ucnt = 0;
    i_tx_ready = 1;
    wait_idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
